tanh_act_rr_scheduler: RTL and testbench
========================================

// Module: tanh_act_rr_scheduler
// PURPOSE
//  Shares one 4-bit approximate tanh core (Config3, circuit 13) among N_REQ requesters.
//  Round-robin arbiter with a valid/ready handshake on every requester, feeding a
//  1-entry output register that has its own valid/ready handshake and a requester tag.
//  Sits between the quantised neuron accumulators and the activation write-back stage.
// PARAMETERS
//  N_REQ    4   number of requesters, legal range 2..8
//  ID_W     2   tag width, must equal clog2(N_REQ)
//  CNT_W    16  width of the completed-transaction counter
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-high
//  req_valid  in   N_REQ      per-requester request valid
//  req_data   in   4*N_REQ    operand; requester i occupies bits [4i+3:4i]
//  req_ready  out  N_REQ      one-hot grant; all zero when no grant is made
//  out_valid  out  1          output register holds a result
//  out_data   out  4          tanh result
//  out_id     out  ID_W       index of the requester that produced out_data
//  out_ready  in   1          downstream accepts the result
//  done_cnt   out  CNT_W      count of results accepted downstream, wraps
// BEHAVIOUR
//  Core function, combinational, for input x[3:0] and result y[3:0]:
//   y0 = x0; y1 = x0; y2 = ~x0 & (x1 | (x3 & x2)); y3 = x1 & x3.
//  Reset values: out_valid=0, out_data=0, out_id=0, done_cnt=0, rr_ptr=0, state=EMPTY.
//   req_ready is 0 in every cycle where reset=1.
//  FSM has two states, tracking the output register:
//   EMPTY: slot is free.
//   FULL:  out_valid=1.
//  Slot is free when (state==EMPTY) or (state==FULL and out_ready=1).
//  Arbitration, only when the slot is free:
//   - Scan i = rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - The first i with req_valid[i]=1 is granted: req_ready[i]=1.
//   - req_ready is combinational from req_valid, rr_ptr, state and out_ready.
//   - Slot not free: req_ready = 0.
//  Transfer on grant g:
//   - Next edge loads out_data=tanh(req_data[g]), out_id=g, out_valid=1.
//   - State goes to FULL; rr_ptr = (g+1) mod N_REQ.
//  No grant:
//   - rr_ptr holds.
//   - If out_valid & out_ready, then out_valid=0 and state goes to EMPTY.
//  Simultaneous drain and grant in FULL:
//   - The old result leaves and the new one loads on the same edge.
//   - State stays FULL. Sustained throughput is 1 result per cycle.
//  Latency: 1 cycle from the request handshake to out_valid.
//  Stall: while out_valid=1 and out_ready=0, out_data and out_id hold stable.
//  Request rule: req_data[i] is sampled only on req_valid[i] & req_ready[i].
//   A requester must hold valid and data until it is granted.
//  Fairness: a requester with valid held high is granted within N_REQ slot-free cycles.
//  done_cnt increments on each out_valid & out_ready, wrapping at 2^CNT_W.
//  Reset mid-operation: the pending result is discarded and all state returns to reset values.
//  X-safety: out_data changes only on a load and never on a drain alone.
// TESTING
//  1 Reset: hold reset 3 cycles with all req_valid=1.
//    -> req_ready=0, out_valid=0, done_cnt=0 throughout.
//  2 Single request: req_valid=4'b0001, req_data[3:0]=4'b1111, out_ready=1.
//    -> next cycle out_valid=1, out_data=4'b1011, out_id=0.
//  3 Round robin: all four valid, out_ready=1.
//    Data: r0=4'b0110, r1=4'b1100, r2=4'b1010, r3=4'b0001.
//    -> grants 0,1,2,3,0 on consecutive cycles.
//    -> results 4'b0100, 4'b0100, 4'b1100, 4'b0011 with ids 0..3.
//  4 Backpressure: out_ready=0 for 5 cycles while r2 is pending.
//    -> out_data/out_id frozen, req_ready=0.
//    -> on release, same-cycle drain and grant; done_cnt +1 per accepted result.
//  5 Reset mid-stall: out_valid=1, out_ready=0, assert reset for 1 cycle.
//    -> out_valid=0, rr_ptr=0; next grant goes to the lowest-index valid requester.
//  6 Counter wrap: CNT_W=4, 17 accepted results.
//    -> done_cnt reads 1.

Source files
------------

// File: rtl/tanh_act_rr_scheduler.sv
// tanh_act_rr_scheduler
//   Shares one 4-bit approximate tanh core among N_REQ requesters.
//   - A round-robin arbiter grants one requester through its valid/ready handshake.
//   - The granted operand passes through the tanh core.
//   - The result lands in a single-entry output register.
//     That register has its own valid/ready handshake and a requester tag.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   req_valid  [N_REQ]     per-requester request valid
//   req_data   [4*N_REQ]   operands, requester i at [4i+3:4i]
//   req_ready  [N_REQ]     one-hot grant (combinational), zero when no grant
//   out_valid              output register holds a result
//   out_data   [4]         tanh result
//   out_id     [ID_W]      requester that produced out_data
//   out_ready              downstream accepts the result
//   done_cnt   [CNT_W]     results accepted downstream, wrapping

// Combinational approximate tanh core.
module tanh_act_core (
    input  logic [3:0] x,
    output logic [3:0] y
);
    assign y = {x[1] & x[3], ~x[0] & (x[1] | (x[3] & x[2])), x[0], x[0]};
endmodule

// One arbiter lane: flags a valid request at or above the round-robin pointer.
// Those requests take priority over wrapped-around ones.
module tanh_act_rr_lane #(
    parameter int ID_W = 2,
    parameter int IDX  = 0
) (
    input  logic            valid,
    input  logic [ID_W-1:0] rr_ptr,
    output logic            hi
);
    localparam logic [ID_W-1:0] MY_IDX = ID_W'(IDX);
    assign hi = valid && (MY_IDX >= rr_ptr);
endmodule

module tanh_act_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [4*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               out_valid,
    output logic [3:0]         out_data,
    output logic [ID_W-1:0]    out_id,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   done_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [3:0]      data;
    } result_t;

    state_t                   state, state_nx;
    logic [ID_W-1:0]          rr_ptr;
    logic [N_REQ-1:0][3:0]    req_lanes;
    logic [N_REQ-1:0]         hi_req;
    logic [N_REQ-1:0]         pick;
    logic                     grant_any;
    logic [ID_W-1:0]          grant_id;
    logic                     slot_free;
    logic                     take;
    logic                     drain;
    logic [3:0]               core_y;
    result_t                  result_nx;

    assign req_lanes = req_data;

    // Rotating priority:
    //   - Requests at or above rr_ptr are searched first, lowest index winning.
    //   - Only if there are none do we fall back to the lowest-index valid
    //     request overall (the wrapped part of the scan).
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        tanh_act_rr_lane #(.ID_W(ID_W), .IDX(i)) u_lane (
            .valid  (req_valid[i]),
            .rr_ptr (rr_ptr),
            .hi     (hi_req[i])
        );
    end

    assign pick = (|hi_req) ? hi_req : req_valid;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
    end

    assign slot_free = (state == EMPTY) || out_ready;
    assign take      = grant_any && slot_free && !reset;
    assign drain     = (state == FULL) && out_ready;

    tanh_act_core u_core (
        .x (req_lanes[grant_id]),
        .y (core_y)
    );

    assign result_nx = '{id: grant_id, data: core_y};

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nx;
    end

    // FSM: next state. A grant always leaves the slot FULL.
    // This holds even when the old result drains on the same edge.
    always_comb begin
        state_nx = state;
        if (take)       state_nx = FULL;
        else if (drain) state_nx = EMPTY;
    end

    // FSM: outputs
    always_comb begin
        req_ready = '0;
        if (take) req_ready[grant_id] = 1'b1;
        out_valid = (state == FULL);
    end

    // Datapath. out_data/out_id change only on a load, so a drain alone or a
    // stall leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_id   <= '0;
            rr_ptr   <= '0;
            done_cnt <= '0;
        end else begin
            if (take) begin
                out_data <= result_nx.data;
                out_id   <= result_nx.id;
                rr_ptr   <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (drain) done_cnt <= done_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_tanh_act_rr_scheduler.sv
module tb_tanh_act_rr_scheduler;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 4;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [3:0]      data;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_REQ-1:0]   req_valid;
    logic [4*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               out_valid;
    logic [3:0]         out_data;
    logic [ID_W-1:0]    out_id;
    logic               out_ready;
    logic [CNT_W-1:0]   done_cnt;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [N_REQ-1:0] sticky;
    logic [N_REQ-1:0] rdy_s;

    tanh_act_rr_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [3:0] data);
        exp_t e;
        e.id   = ID_W'(id);
        e.data = data;
        sb.push_back(e);
    endtask

    // One cycle: check grant / out_valid / done_cnt mid-cycle, then the
    // requesters drop valid on grant (except sticky ones, which re-request).
    task automatic step(input logic [N_REQ-1:0] exp_rdy, input logic exp_ov, input int exp_cnt);
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("done_cnt", 32'(done_cnt), 32'(exp_cnt % 16));
        rdy_s = req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(rdy_s & ~sticky);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every output handshake pops one expected result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got id=%0d data=%b expected no result", out_id, out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_id", 32'(out_id), 32'(e.id));
                chk("out_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 4'hF; req_data = '0; out_ready = 1'b1; sticky = '0;

        // 1: reset held 3 cycles with every request valid
        repeat (3) begin
            @(negedge clk);
            chk("t1_req_ready", 32'(req_ready), 32'd0);
            chk("t1_out_valid", 32'(out_valid), 32'd0);
            chk("t1_done_cnt", 32'(done_cnt), 32'd0);
            @(posedge clk);
        end
        #1;
        reset = 1'b0; req_valid = '0;

        // 2: single request, tanh(1111) = 1011
        req_data[3:0] = 4'b1111; req_valid = 4'b0001;
        push(0, 4'b1011);
        step(4'b0001, 1'b0, 0);
        step(4'b0000, 1'b1, 0);
        do_reset();

        // 3: round robin, r0 keeps re-requesting so the scan wraps back to it
        req_data = {4'b0001, 4'b1010, 4'b1100, 4'b0110};
        req_valid = 4'b1111; sticky = 4'b0001;
        push(0, 4'b0100); push(1, 4'b0100); push(2, 4'b1100); push(3, 4'b0011); push(0, 4'b0100);
        step(4'b0001, 1'b0, 0);
        step(4'b0010, 1'b1, 0);
        step(4'b0100, 1'b1, 1);
        step(4'b1000, 1'b1, 2);
        sticky = '0;
        step(4'b0001, 1'b1, 3);
        step(4'b0000, 1'b1, 4);

        // 4: backpressure with r2 pending behind r1's result
        req_valid = 4'b0010;
        push(1, 4'b0100);
        step(4'b0010, 1'b0, 5);
        out_ready = 1'b0; req_valid = 4'b0100;
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_ready", 32'(req_ready), 32'd0);
            chk("t4_stall_valid", 32'(out_valid), 32'd1);
            chk("t4_stall_data", 32'(out_data), 32'b0100);
            chk("t4_stall_id", 32'(out_id), 32'd1);
            chk("t4_stall_cnt", 32'(done_cnt), 32'd5);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        push(2, 4'b1100);
        step(4'b0100, 1'b1, 5);   // drain r1 and grant r2 on the same edge
        step(4'b0000, 1'b1, 6);

        // 5: reset while stalled; pointer returns to 0
        out_ready = 1'b0; req_valid = 4'b1000;
        step(4'b1000, 1'b0, 7);
        reset = 1'b1; req_valid = 4'b0110;
        @(negedge clk);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0; out_ready = 1'b1;
        push(1, 4'b0100); push(2, 4'b1100);
        step(4'b0010, 1'b0, 0);
        step(4'b0100, 1'b1, 0);
        step(4'b0000, 1'b1, 1);
        do_reset();

        // 6: 17 accepted results wrap a 4-bit counter to 1
        req_data[3:0] = 4'b1111; req_valid = 4'b0001; sticky = 4'b0001;
        for (int k = 0; k < 17; k++) begin
            push(0, 4'b1011);
            if (k == 16) sticky = '0;
            step(4'b0001, (k > 0), (k > 0) ? k - 1 : 0);
        end
        step(4'b0000, 1'b1, 16);
        @(negedge clk);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_data_hold", 32'(out_data), 32'b1011);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
